// File: rtl/color_fsm_sequencer.sv
// Sequencer that steers the colour FSM (BLUE/RED/HSV_IDLE) to a requested state
// along the shortest legal command path, checking its output after every step.
`timescale 1ns/1ps

module color_fsm_sequencer #(
    parameter int DWELL = 1,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_target,
    output logic       req_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_err,
    output logic [1:0] rsp_steps,
    output logic [1:0] fsm_cmd,
    input  logic [1:0] fsm_out,
    output logic [1:0] cur_state,
    output logic       busy,
    output logic       desync
);
    // Handshakes: a request transfers on a clock edge where req_valid && req_ready;
    // a response transfers where rsp_valid && rsp_ready, and its fields stay
    // stable from the rising of rsp_valid until that edge.

    localparam logic [1:0] C_BLUE  = 2'd0;
    localparam logic [1:0] C_RED   = 2'd1;
    localparam logic [1:0] C_HSV   = 2'd2;
    localparam logic [1:0] C_ILL   = 2'd3;
    localparam logic [1:0] CMD_NOP = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_SETTLE, S_RESP} state_t;

    state_t           r_state;
    logic [1:0]       r_target;
    logic [1:0]       r_next;
    logic [1:0]       r_steps;
    logic [CNT_W-1:0] r_dwell;
    logic             r_err;
    logic             r_desync;
    logic [1:0]       r_cmd;
    logic [1:0]       r_cur;

    logic [3:0]       w_path;
    logic [1:0]       w_exp_out;

    // Returns {command, resulting state} for the first hop from cur toward tgt.
    function automatic logic [3:0] path_step(input logic [1:0] cur, input logic [1:0] tgt);
        case (cur)
            C_BLUE:  return {2'd1, C_RED};
            C_RED:   return (tgt == C_BLUE) ? {2'd1, C_BLUE} : {2'd2, C_HSV};
            default: return {2'd0, C_RED};
        endcase
    endfunction

    assign w_path    = path_step(r_cur, (r_state == S_IDLE) ? req_target : r_target);
    assign w_exp_out = (r_cur == C_BLUE) ? 2'd1 : 2'd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_target <= C_RED;
            r_next   <= C_RED;
            r_steps  <= 2'd0;
            r_dwell  <= '0;
            r_err    <= 1'b0;
            r_desync <= 1'b0;
            r_cmd    <= CMD_NOP;
            r_cur    <= C_RED;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_target <= req_target;
                        r_steps  <= 2'd0;
                        if (req_target == r_cur || req_target == C_ILL || r_desync) begin
                            r_err   <= (req_target == C_ILL) || r_desync;
                            r_state <= S_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_cmd   <= w_path[3:2];
                            r_next  <= w_path[1:0];
                            r_state <= S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    r_cur   <= r_next;
                    r_steps <= r_steps + 2'd1;
                    r_dwell <= CNT_W'(DWELL);
                    r_cmd   <= CMD_NOP;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_dwell > CNT_W'(1)) begin
                        r_dwell <= r_dwell - CNT_W'(1);
                    end else if (fsm_out != w_exp_out) begin
                        r_desync <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= S_RESP;
                    end else if (r_cur == r_target) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cmd   <= w_path[3:2];
                        r_next  <= w_path[1:0];
                        r_state <= S_STEP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);
    assign rsp_err   = r_err;
    assign rsp_steps = r_steps;
    assign fsm_cmd   = r_cmd;
    assign cur_state = r_cur;
    assign desync    = r_desync;

endmodule

// File: doc/color_fsm_sequencer.md
Name: color_fsm_sequencer

Overview:
- Controller that drives the 2-bit command input of the colour state machine (states BLUE, RED, HSV_IDLE) so the machine reaches a requested target state.
- Issues the shortest legal command sequence, one step at a time, and waits a programmable dwell after each step.
- Checks the machine's 2-bit output after each step and returns a completion response through a valid/ready handshake.
- Sits between the configuration/control logic and the colour FSM instance; it is the only driver of that FSM's command input.

Parameters:
- DWELL, 1, settle cycles after each command step before the output check (legal 1..15).
- CNT_W, 4, width of the dwell counter (must hold DWELL).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req_valid  input  1  target request valid
- req_target  input  2  target state: 0=BLUE, 1=RED, 2=HSV_IDLE, 3=illegal
- req_ready  output  1  sequencer can accept a request
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accepted
- rsp_err  output  1  response error flag
- rsp_steps  output  2  number of command steps issued for this request
- fsm_cmd  output  2  command to the colour FSM input
- fsm_out  input  2  colour FSM output
- cur_state  output  2  mirrored FSM state, same encoding as req_target
- busy  output  1  sequencer is not in IDLE
- desync  output  1  sticky mirror/output mismatch flag

Behaviour:
- Controlled FSM transitions (fixed):
  - BLUE: cmd 1 -> RED.
  - RED: cmd 1 -> BLUE; cmd 0 -> RED; cmd 2 -> HSV_IDLE.
  - HSV_IDLE: cmd 0 -> RED.
  - cmd 3 (NOP) never causes a transition.
  - Expected output per state: BLUE -> 1, RED -> 2, HSV_IDLE -> 2. The FSM resets to RED on the same rst.
- Reset values:
  - State = IDLE, fsm_cmd = 3 (NOP), cur_state = 1 (RED).
  - req_ready = 1; rsp_valid = 0, rsp_err = 0, rsp_steps = 0, busy = 0, desync = 0.
- Controller states and transitions:
  - IDLE: req_ready = 1. On req_valid, latch the target, clear the step count and compute the path.
    - If target == cur_state, target == 3, or desync == 1, go directly to RESP with zero steps. rsp_err = 1 for target 3 or desync.
    - Otherwise go to STEP.
  - STEP: one cycle. Drive fsm_cmd with the next command on the path, update cur_state to the next state, increment the step count, load the dwell counter with DWELL. Go to SETTLE.
  - SETTLE: fsm_cmd = NOP. Count down DWELL cycles. On the last cycle compare fsm_out with the expected output for cur_state.
    - Mismatch: set desync (sticky), set rsp_err, go to RESP.
    - Match with cur_state == target: go to RESP.
    - Match otherwise: go to STEP.
  - RESP: hold rsp_valid, rsp_err and rsp_steps stable until rsp_ready; return to IDLE on the handshake. req_ready = 0.
- Paths (commands in order):
  - BLUE->RED: 1
  - BLUE->HSV: 1, 2
  - RED->BLUE: 1
  - RED->HSV: 2
  - HSV->RED: 0
  - HSV->BLUE: 0, 1
  - Maximum 2 steps.
- Latency for a request accepted at edge 0 with k steps: rsp_valid rises after k*(1+DWELL) + 1 cycles. With k = 0, rsp_valid rises the cycle after acceptance.
- busy = 1 in STEP, SETTLE and RESP.
- fsm_cmd is NOP in every state except STEP.
- req_ready is low whenever not in IDLE. A request held during busy is accepted only on the first IDLE cycle.
- desync clears only on rst.
- rst asserted mid-operation: immediate return to reset values. Any in-flight response is discarded.
- rsp_ready asserted outside RESP is ignored.

Test Plan:
- Reset, then request target 0 (BLUE) with DWELL=1 -> fsm_cmd = 1 for one cycle, fsm_out = 1 after the settle, rsp_valid with rsp_err = 0, rsp_steps = 1, cur_state = 0.
- From BLUE, request target 2 -> fsm_cmd sequence 1, NOP, 2, NOP; rsp_steps = 2; rsp_valid 5 cycles after acceptance; cur_state = 2.
- From RED, request target 1 -> no command issued, rsp_valid next cycle, rsp_steps = 0, rsp_err = 0; request target 3 -> rsp_err = 1, cur_state unchanged.
- Force fsm_out = 2 while expecting BLUE -> rsp_err = 1, desync = 1; a following request for RED returns rsp_err = 1, rsp_steps = 0, and fsm_cmd stays NOP.
- Hold rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_err and rsp_steps stable, req_ready = 0, and a pending req_valid is not accepted until after the handshake.
- Assert rst during SETTLE of HSV->BLUE -> cur_state = 1, fsm_cmd = 3, rsp_valid = 0, busy = 0, and the FSM is back in RED.
